vector_spad_bridge: RTL and testbench
=====================================

# vector_spad_bridge

Responder for vector-unit scratchpad traffic. Accepts one full-vector load or store request from the vector unit, carrying destination, row/col, swizzle and mask. Splits it into fixed-width scratchpad beats, honouring swizzle addressing and element masks. Returns a single completion carrying the assembled load data or the store ack, with an error code. Sits between the vector unit's memory-side signals and one scratchpad bank port.

## Interface
Parameters:
- NUM_ELEMENTS, 32: elements per vector register.
- ELEM_W, 16: element width (FP16).
- BEAT_ELEMS, 8: elements per scratchpad beat; must divide NUM_ELEMENTS. NUM_BEATS = NUM_ELEMENTS/BEAT_ELEMS.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge idle, can accept.
- req_wen  in  1  1 = store, 0 = load.
- req_vd  in  5  destination/source vector register tag.
- req_row  in  12  base row.
- req_col  in  12  base column, in elements.
- req_swizzle  in  1  transposed (tile) addressing.
- req_vmask  in  NUM_ELEMENTS  element enables.
- req_vdata  in  NUM_ELEMENTS*ELEM_W  store data.
- sp_valid  out  1  beat request valid.
- sp_ready  in  1  scratchpad accepts beat.
- sp_wen  out  1  beat is a write.
- sp_row  out  12  beat row.
- sp_col  out  12  beat column.
- sp_wdata  out  BEAT_ELEMS*ELEM_W  write data.
- sp_wstrb  out  BEAT_ELEMS  per-element write strobe.
- sp_rvalid  in  1  read data returned.
- sp_rdata  in  BEAT_ELEMS*ELEM_W  read data.
- resp_valid  out  1  completion pulse, one cycle, no backpressure.
- resp_wen  out  1  echo of req_wen.
- resp_vd  out  5  echo of req_vd.
- resp_vdata  out  NUM_ELEMENTS*ELEM_W  load result; zero for stores.
- resp_error  out  5  bit0 misaligned, bit1 out of range, bits[4:2] = 0.

## Operation
- States: IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- req_ready = 1 only in IDLE. Request is latched on req_valid & req_ready; beat counter b = 0.
- Error checks at accept:
  - misaligned if req_col % BEAT_ELEMS != 0.
  - out of range if non-swizzle and req_col + NUM_ELEMENTS > 4096, or swizzle and req_row + NUM_BEATS > 4096.
  - On any error: go straight to RESP, no scratchpad access, resp_vdata = 0.
- Beat addresses:
  - non-swizzle: (row, col + b*BEAT_ELEMS).
  - swizzle: (row + b, col).
  - Beat b always carries vector elements [b*BEAT_ELEMS +: BEAT_ELEMS].
- Store (WRITE):
  - sp_wstrb is the matching vmask slice.
  - Beats whose mask slice is all zero are skipped: not issued, zero cycles.
  - sp_valid and beat fields are held stable until sp_ready.
  - After the last issued beat, go to RESP. An all-zero vmask goes directly to RESP.
- Load:
  - READ_REQ issues beat b, skipping all-zero-mask beats as for stores. Handshake moves to READ_WAIT.
  - In READ_WAIT, sp_rvalid writes sp_rdata into slot b, with masked-off elements forced to 0. Then b advances to READ_REQ, or to RESP after the last beat.
  - Skipped slots read 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- sp_rvalid outside READ_WAIT is ignored.

## Timing
- Reset values: req_ready = 1 (state IDLE); sp_valid, sp_wen, sp_row, sp_col, sp_wdata, sp_wstrb, resp_* = 0.
- Accept in cycle 0 → first sp_valid in cycle 1. No combinational path from req_* to sp_*.
- Store with full mask and sp_ready tied high: beats in cycles 1–4, resp_valid in cycle 5 (NUM_BEATS = 4).
- Load with full mask, sp_ready high, 1-cycle read latency: each beat takes 2 cycles (req, rvalid); resp_valid in cycle 9.
- Error, or all-zero mask: resp_valid in cycle 1.
- sp_rvalid in the same cycle as its request handshake is illegal; the scratchpad guarantees ≥1 cycle.
- Only one request and one beat outstanding.
- nRST low mid-operation: at the next edge, state = IDLE, all outputs at reset values, the partial vector is discarded and no resp is emitted. A late sp_rvalid is ignored.

## Structure
- Add to vector_pkg: BEAT_ELEMS, NUM_BEATS, bridge_state_t enum, spad_beat_t struct (wen, row, col, wdata, wstrb), and error-bit constants ERR_MISALIGN and ERR_RANGE.
- One sub-module: vspad_addr_gen. It is combinational: (row, col, swizzle, b) → (sp_row, sp_col), plus the range/alignment error flags.

## Test plan
- Store, non-swizzle, row 5, col 16, full mask, sp_ready high → beats at (5,16), (5,24), (5,32), (5,40), wstrb 0xFF each; resp_valid in cycle 5, error 0.
- Load, swizzle, row 10, col 8, 1-cycle rdata → beats at rows 10–13, col 8; resp_vdata concatenates beats in order; resp in cycle 9.
- Store, vmask 0x00FF00F0 → only beats 0 (wstrb 0xF0) and 2 (wstrb 0xFF) issued; resp after 2 beats.
- col 4 → resp_error = 5'b00001 in cycle 1, no sp_valid. Non-swizzle col 4080 → resp_error = 5'b00010.
- sp_ready low 3 cycles on beat 1 → beat fields stable throughout; total latency +3.
- nRST low during READ_WAIT of beat 2, then late sp_rvalid → no resp, req_ready = 1 next cycle, next request completes normally.

Source files
------------

// File: rtl/vector_spad_bridge_pkg.sv
// Shared vector/scratchpad types and constants for the vector_spad_bridge slice.
package vector_pkg;

  localparam int unsigned VEC_ELEMS   = 32;
  localparam int unsigned VEC_ELEM_W  = 16;
  localparam int unsigned BEAT_ELEMS  = 8;
  localparam int unsigned NUM_BEATS   = VEC_ELEMS / BEAT_ELEMS;
  localparam int unsigned SPAD_ADDR_W = 12;
  localparam int unsigned ERR_W       = 5;

  // Bit positions inside resp_error
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_RESP
  } bridge_state_t;

  typedef struct packed {
    logic                               wen;
    logic [SPAD_ADDR_W-1:0]             row;
    logic [SPAD_ADDR_W-1:0]             col;
    logic [BEAT_ELEMS*VEC_ELEM_W-1:0]   wdata;
    logic [BEAT_ELEMS-1:0]              wstrb;
  } spad_beat_t;

endpackage

// File: rtl/vector_spad_bridge_if.sv
// Vector-unit request/response bundle and scratchpad bank port bundle.
interface vec_req_if #(
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned ELEM_W       = 16
);
  import vector_pkg::*;

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_wen;
  logic [4:0]                       req_vd;
  logic [SPAD_ADDR_W-1:0]           req_row;
  logic [SPAD_ADDR_W-1:0]           req_col;
  logic                             req_swizzle;
  logic [NUM_ELEMENTS-1:0]          req_vmask;
  logic [NUM_ELEMENTS*ELEM_W-1:0]   req_vdata;
  logic                             resp_valid;
  logic                             resp_wen;
  logic [4:0]                       resp_vd;
  logic [NUM_ELEMENTS*ELEM_W-1:0]   resp_vdata;
  logic [ERR_W-1:0]                 resp_error;

  modport master (
    output req_valid, req_wen, req_vd, req_row, req_col, req_swizzle, req_vmask, req_vdata,
    input  req_ready, resp_valid, resp_wen, resp_vd, resp_vdata, resp_error
  );

  modport slave (
    input  req_valid, req_wen, req_vd, req_row, req_col, req_swizzle, req_vmask, req_vdata,
    output req_ready, resp_valid, resp_wen, resp_vd, resp_vdata, resp_error
  );
endinterface

interface spad_if #(
  parameter int unsigned BEAT_ELEMS = 8,
  parameter int unsigned ELEM_W     = 16
);
  import vector_pkg::*;

  logic                           sp_valid;
  logic                           sp_ready;
  logic                           sp_wen;
  logic [SPAD_ADDR_W-1:0]         sp_row;
  logic [SPAD_ADDR_W-1:0]         sp_col;
  logic [BEAT_ELEMS*ELEM_W-1:0]   sp_wdata;
  logic [BEAT_ELEMS-1:0]          sp_wstrb;
  logic                           sp_rvalid;
  logic [BEAT_ELEMS*ELEM_W-1:0]   sp_rdata;

  modport master (
    output sp_valid, sp_wen, sp_row, sp_col, sp_wdata, sp_wstrb,
    input  sp_ready, sp_rvalid, sp_rdata
  );

  modport slave (
    input  sp_valid, sp_wen, sp_row, sp_col, sp_wdata, sp_wstrb,
    output sp_ready, sp_rvalid, sp_rdata
  );
endinterface

// File: rtl/vector_spad_bridge_addr_gen.sv
// Combinational beat address generator with alignment/range checks.
module vspad_addr_gen #(
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned BEAT_ELEMS   = 8,
  parameter int unsigned BW           = 2
) (
  input  logic [11:0]   row,
  input  logic [11:0]   col,
  input  logic          swizzle,
  input  logic [BW-1:0] beat,
  output logic [11:0]   sp_row,
  output logic [11:0]   sp_col,
  output logic          misaligned,
  output logic          out_of_range
);
  localparam int unsigned NUM_BEATS = NUM_ELEMENTS / BEAT_ELEMS;

  logic [11:0] col_rem;
  logic [12:0] row_end;
  logic [12:0] col_end;

  always_comb begin
    col_rem      = col % 12'(BEAT_ELEMS);
    row_end      = {1'b0, row} + 13'(NUM_BEATS);
    col_end      = {1'b0, col} + 13'(NUM_ELEMENTS);
    misaligned   = (col_rem != '0);
    out_of_range = swizzle ? (row_end > 13'd4096) : (col_end > 13'd4096);
    sp_row       = swizzle ? row + 12'(beat) : row;
    sp_col       = swizzle ? col : col + 12'(32'(beat) * BEAT_ELEMS);
  end
endmodule

// File: rtl/vector_spad_bridge.sv
// Splits one vector load/store into scratchpad beats and returns a single completion.
module vector_spad_bridge #(
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned ELEM_W       = 16,
  parameter int unsigned BEAT_ELEMS   = 8
) (
  input  logic     CLK,
  input  logic     nRST,
  vec_req_if.slave vec,
  spad_if.master   sp
);
  localparam int unsigned NUM_BEATS = NUM_ELEMENTS / BEAT_ELEMS;
  localparam int unsigned BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned SW        = BW + 1;
  localparam int unsigned BEAT_W    = BEAT_ELEMS * ELEM_W;
  localparam int unsigned VEC_W     = NUM_ELEMENTS * ELEM_W;

  import vector_pkg::*;

  bridge_state_t state, state_n;

  logic [BW-1:0]           b_q;
  logic                    wen_q;
  logic                    swz_q;
  logic [4:0]              vd_q;
  logic [11:0]             row_q;
  logic [11:0]             col_q;
  logic [NUM_ELEMENTS-1:0] vmask_q;
  logic [VEC_W-1:0]        vdata_q;
  logic [VEC_W-1:0]        rdata_q;
  logic [ERR_W-1:0]        err_q;
  spad_beat_t              beat_q;

  logic                    accept;
  logic                    load_beat;
  logic                    capture;
  logic [NUM_ELEMENTS-1:0] srch_mask;
  logic [SW-1:0]           srch_from;
  logic                    found;
  logic [BW-1:0]           found_b;
  logic [11:0]             ag_row_in, ag_col_in, ag_row, ag_col;
  logic                    ag_swz, ag_mis, ag_oor;
  logic [ERR_W-1:0]        err_vec;
  logic [VEC_W-1:0]        data_src;
  logic [BEAT_ELEMS-1:0]   beat_mask;
  logic [BEAT_W-1:0]       rmasked;

  // In IDLE everything is taken straight from the request so the first beat is ready next cycle
  always_comb begin
    ag_row_in = (state == ST_IDLE) ? vec.req_row : row_q;
    ag_col_in = (state == ST_IDLE) ? vec.req_col : col_q;
    ag_swz    = (state == ST_IDLE) ? vec.req_swizzle : swz_q;
    data_src  = (state == ST_IDLE) ? vec.req_vdata : vdata_q;
  end

  vspad_addr_gen #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .BEAT_ELEMS   (BEAT_ELEMS),
    .BW           (BW)
  ) u_addr_gen (
    .row          (ag_row_in),
    .col          (ag_col_in),
    .swizzle      (ag_swz),
    .beat         (found_b),
    .sp_row       (ag_row),
    .sp_col       (ag_col),
    .misaligned   (ag_mis),
    .out_of_range (ag_oor)
  );

  // Next issued beat: first index at or after srch_from with a non-empty mask slice
  always_comb begin
    found   = 1'b0;
    found_b = '0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      if (!found && (i >= 32'(srch_from)) && (|srch_mask[i*BEAT_ELEMS +: BEAT_ELEMS])) begin
        found   = 1'b1;
        found_b = BW'(i);
      end
    end
  end

  always_comb begin
    err_vec               = '0;
    err_vec[ERR_MISALIGN] = ag_mis;
    err_vec[ERR_RANGE]    = ag_oor;
    beat_mask             = vmask_q[b_q*BEAT_ELEMS +: BEAT_ELEMS];
    rmasked               = '0;
    for (int unsigned e = 0; e < BEAT_ELEMS; e++) begin
      if (beat_mask[e]) rmasked[e*ELEM_W +: ELEM_W] = sp.sp_rdata[e*ELEM_W +: ELEM_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    load_beat = 1'b0;
    capture   = 1'b0;
    srch_mask = vmask_q;
    srch_from = {1'b0, b_q} + SW'(1);
    unique case (state)
      ST_IDLE: begin
        srch_mask = vec.req_vmask;
        srch_from = '0;
        if (vec.req_valid) begin
          accept = 1'b1;
          if (ag_mis || ag_oor || !found) begin
            state_n = ST_RESP;
          end else begin
            load_beat = 1'b1;
            state_n   = vec.req_wen ? ST_WRITE : ST_READ_REQ;
          end
        end
      end
      ST_WRITE: begin
        if (sp.sp_ready) begin
          if (found) load_beat = 1'b1;
          else       state_n   = ST_RESP;
        end
      end
      ST_READ_REQ: begin
        if (sp.sp_ready) state_n = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (sp.sp_rvalid) begin
          capture = 1'b1;
          if (found) begin
            load_beat = 1'b1;
            state_n   = ST_READ_REQ;
          end else begin
            state_n = ST_RESP;
          end
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      b_q     <= '0;
      wen_q   <= 1'b0;
      swz_q   <= 1'b0;
      vd_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vmask_q <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      beat_q  <= '0;
    end else begin
      if (accept) begin
        b_q     <= '0;
        wen_q   <= vec.req_wen;
        swz_q   <= vec.req_swizzle;
        vd_q    <= vec.req_vd;
        row_q   <= vec.req_row;
        col_q   <= vec.req_col;
        vmask_q <= vec.req_vmask;
        vdata_q <= vec.req_vdata;
        rdata_q <= '0;
        err_q   <= err_vec;
      end
      if (load_beat) begin
        b_q          <= found_b;
        beat_q.wen   <= accept ? vec.req_wen : wen_q;
        beat_q.row   <= ag_row;
        beat_q.col   <= ag_col;
        beat_q.wdata <= (accept ? vec.req_wen : wen_q) ? data_src[found_b*BEAT_W +: BEAT_W] : '0;
        beat_q.wstrb <= (accept ? vec.req_wen : wen_q) ? srch_mask[found_b*BEAT_ELEMS +: BEAT_ELEMS] : '0;
      end
      if (capture) rdata_q[b_q*BEAT_W +: BEAT_W] <= rmasked;
    end
  end

  assign vec.req_ready  = (state == ST_IDLE);
  assign vec.resp_valid = (state == ST_RESP);
  assign vec.resp_wen   = (state == ST_RESP) && wen_q;
  assign vec.resp_vd    = (state == ST_RESP) ? vd_q : '0;
  assign vec.resp_vdata = ((state == ST_RESP) && !wen_q) ? rdata_q : '0;
  assign vec.resp_error = (state == ST_RESP) ? err_q : '0;

  assign sp.sp_valid = (state == ST_WRITE) || (state == ST_READ_REQ);
  assign sp.sp_wen   = beat_q.wen;
  assign sp.sp_row   = beat_q.row;
  assign sp.sp_col   = beat_q.col;
  assign sp.sp_wdata = beat_q.wdata;
  assign sp.sp_wstrb = beat_q.wstrb;
endmodule

// File: tb/tb_vector_spad_bridge.sv
// Randomised bench for vector_spad_bridge against a transaction-level model.
module tb_vector_spad_bridge;
  localparam int unsigned NE  = 32;
  localparam int unsigned EW  = 16;
  localparam int unsigned BE  = 8;
  localparam int unsigned NB  = NE / BE;
  localparam int unsigned VW  = NE * EW;
  localparam int unsigned BTW = BE * EW;

  typedef struct {
    logic [11:0]    row;
    logic [11:0]    col;
    logic [BE-1:0]  strb;
    logic [BTW-1:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vec_req_if #(.NUM_ELEMENTS(NE), .ELEM_W(EW)) vif ();
  spad_if    #(.BEAT_ELEMS(BE), .ELEM_W(EW))   sif ();

  vector_spad_bridge #(
    .NUM_ELEMENTS (NE),
    .ELEM_W       (EW),
    .BEAT_ELEMS   (BE)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .vec  (vif),
    .sp   (sif)
  );

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scratchpad contents as a pure function of address
  function automatic logic [EW-1:0] mem_elem(input logic [11:0] r, input logic [11:0] c);
    return EW'((32'(r) * 131 + 32'(c) * 7 + 3) ^ 32'h5a5a);
  endfunction

  task automatic drive_rdata(input logic [11:0] r, input logic [11:0] c);
    for (int e = 0; e < BE; e++) sif.sp_rdata[e*EW +: EW] = mem_elem(r, 12'(32'(c) + e));
  endtask

  task automatic run_txn(input logic wen, input logic [4:0] vd, input logic [11:0] row,
                         input logic [11:0] col, input logic swz, input logic [NE-1:0] mask,
                         input logic [VW-1:0] data, input int stall_beat, input int stall_len);
    beat_t       exp_q[$];
    logic [VW-1:0] exp_vdata;
    logic [4:0]  exp_err;
    int          exp_lat, nbeat, stall_left, cyc;
    bit          rd_pend, done;
    logic [11:0] last_row, last_col;

    exp_err   = '0;
    exp_vdata = '0;
    if ((32'(col) % BE) != 0) exp_err[0] = 1'b1;
    if (swz ? (32'(row) + NB > 4096) : (32'(col) + NE > 4096)) exp_err[1] = 1'b1;
    if (exp_err == '0) begin
      for (int b = 0; b < NB; b++) begin
        beat_t t;
        t.strb  = mask[b*BE +: BE];
        t.row   = swz ? 12'(32'(row) + b) : row;
        t.col   = swz ? col : 12'(32'(col) + b * BE);
        t.wdata = data[b*BTW +: BTW];
        if (t.strb != '0) begin
          exp_q.push_back(t);
          if (!wen)
            for (int e = 0; e < BE; e++)
              if (t.strb[e]) exp_vdata[(b*BE+e)*EW +: EW] = mem_elem(t.row, 12'(32'(t.col) + e));
        end
      end
    end
    exp_lat = 1 + exp_q.size() * (wen ? 1 : 2) + ((stall_beat < exp_q.size()) ? stall_len : 0);

    @(negedge clk);
    check_eq("req_ready", vif.req_ready, 1'b1);
    vif.req_valid   = 1'b1;
    vif.req_wen     = wen;
    vif.req_vd      = vd;
    vif.req_row     = row;
    vif.req_col     = col;
    vif.req_swizzle = swz;
    vif.req_vmask   = mask;
    vif.req_vdata   = data;
    cyc = 0; nbeat = 0; stall_left = stall_len; rd_pend = 0; done = 0;
    last_row = '0; last_col = '0;

    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      vif.req_valid  = 1'b0;
      vif.req_vmask  = NE'($urandom);
      sif.sp_ready   = 1'b1;
      sif.sp_rvalid  = 1'b0;
      sif.sp_rdata   = {4{$urandom}};
      if (rd_pend) begin
        sif.sp_rvalid = 1'b1;
        drive_rdata(last_row, last_col);
        rd_pend = 0;
      end else if (wen && $urandom_range(0, 3) == 0) begin
        sif.sp_rvalid = 1'b1;
      end
      if (sif.sp_valid) begin
        if (nbeat >= exp_q.size()) begin
          check_eq("beat_count", nbeat + 1, exp_q.size());
          done = 1;
        end else begin
          check_eq("sp_row", sif.sp_row, exp_q[nbeat].row);
          check_eq("sp_col", sif.sp_col, exp_q[nbeat].col);
          check_eq("sp_wen", sif.sp_wen, wen);
          if (wen) begin
            check_eq("sp_wstrb", sif.sp_wstrb, exp_q[nbeat].strb);
            check_eq("sp_wdata", sif.sp_wdata, exp_q[nbeat].wdata);
          end
          if (nbeat == stall_beat && stall_left > 0) begin
            sif.sp_ready = 1'b0;
            stall_left--;
          end else begin
            if (!wen) begin
              rd_pend  = 1;
              last_row = sif.sp_row;
              last_col = sif.sp_col;
            end
            nbeat++;
          end
        end
      end
      if (vif.resp_valid) begin
        check_eq("resp_cycle", cyc, exp_lat);
        check_eq("beat_count", nbeat, exp_q.size());
        check_eq("resp_wen", vif.resp_wen, wen);
        check_eq("resp_vd", vif.resp_vd, vd);
        check_eq("resp_error", vif.resp_error, exp_err);
        check_eq("resp_vdata", vif.resp_vdata, exp_vdata);
        done = 1;
      end
    end
    if (!done) check_eq("resp_timeout", cyc, exp_lat);

    @(negedge clk);
    sif.sp_rvalid = 1'b0;
    sif.sp_ready  = 1'b1;
    check_eq("resp_pulse", vif.resp_valid, 1'b0);
    check_eq("idle_ready", vif.req_ready, 1'b1);
  endtask

  initial begin
    logic [VW-1:0] d;
    bit            pend;

    vif.req_valid = 1'b0; vif.req_wen = 1'b0; vif.req_vd = '0; vif.req_row = '0;
    vif.req_col = '0; vif.req_swizzle = 1'b0; vif.req_vmask = '0; vif.req_vdata = '0;
    sif.sp_ready = 1'b1; sif.sp_rvalid = 1'b0; sif.sp_rdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", vif.req_ready, 1'b1);
    check_eq("rst_sp_valid", sif.sp_valid, 1'b0);
    check_eq("rst_sp_fields", {sif.sp_wen, sif.sp_row, sif.sp_col, sif.sp_wstrb, sif.sp_wdata}, '0);
    check_eq("rst_resp", {vif.resp_valid, vif.resp_wen, vif.resp_vd, vif.resp_error}, '0);
    check_eq("rst_resp_vdata", vif.resp_vdata, '0);
    nrst = 1'b1;

    for (int w = 0; w < int'(VW / 32); w++) d[w*32 +: 32] = $urandom;

    // Directed cases
    run_txn(1'b1, 5'd3, 12'd5, 12'd16, 1'b0, '1, d, 0, 0);
    run_txn(1'b0, 5'd7, 12'd10, 12'd8, 1'b1, '1, d, 0, 0);
    run_txn(1'b1, 5'd1, 12'd20, 12'd64, 1'b0, 32'h00FF00F0, d, 0, 0);
    run_txn(1'b0, 5'd2, 12'd0, 12'd4, 1'b0, '1, d, 0, 0);
    run_txn(1'b1, 5'd2, 12'd0, 12'd4080, 1'b0, '1, d, 0, 0);
    run_txn(1'b0, 5'd9, 12'd4093, 12'd0, 1'b1, '1, d, 0, 0);
    run_txn(1'b1, 5'd4, 12'd33, 12'd128, 1'b0, '0, d, 0, 0);
    run_txn(1'b1, 5'd5, 12'd6, 12'd24, 1'b0, '1, d, 1, 3);
    run_txn(1'b0, 5'd6, 12'd6, 12'd24, 1'b1, 32'hF0000F0F, d, 1, 3);

    // Reset in READ_WAIT of beat 2, followed by a late sp_rvalid
    @(negedge clk);
    vif.req_valid = 1'b1; vif.req_wen = 1'b0; vif.req_vd = 5'd11; vif.req_row = 12'd3;
    vif.req_col = 12'd64; vif.req_swizzle = 1'b0; vif.req_vmask = '1;
    pend = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vif.req_valid = 1'b0;
      sif.sp_rvalid = pend;
      drive_rdata(12'd3, 12'd64);
      pend = sif.sp_valid;
    end
    @(negedge clk);
    check_eq("rw2_sp_valid", sif.sp_valid, 1'b0);
    sif.sp_rvalid = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    sif.sp_rvalid = 1'b1;
    check_eq("mid_rst_ready", vif.req_ready, 1'b1);
    check_eq("mid_rst_sp_valid", sif.sp_valid, 1'b0);
    check_eq("mid_rst_sp_fields", {sif.sp_wen, sif.sp_row, sif.sp_col, sif.sp_wstrb, sif.sp_wdata}, '0);
    check_eq("mid_rst_resp", vif.resp_valid, 1'b0);
    @(negedge clk);
    sif.sp_rvalid = 1'b0;
    check_eq("late_rvalid_resp", vif.resp_valid, 1'b0);
    check_eq("late_rvalid_ready", vif.req_ready, 1'b1);
    check_eq("late_rvalid_sp", sif.sp_valid, 1'b0);
    run_txn(1'b0, 5'd12, 12'd3, 12'd64, 1'b0, '1, d, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      logic [NE-1:0] m;
      logic [11:0]   r, c;
      for (int b = 0; b < int'(NB); b++) m[b*BE +: BE] = ($urandom_range(0, 3) == 0) ? '0 : BE'($urandom);
      for (int w = 0; w < int'(VW / 32); w++) d[w*32 +: 32] = $urandom;
      r = ($urandom_range(0, 7) == 0) ? 12'(4090 + $urandom_range(0, 5)) : 12'($urandom_range(0, 4095));
      c = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'(8 * $urandom_range(0, 511));
      run_txn(1'($urandom_range(0, 1)), 5'($urandom), r, c, 1'($urandom_range(0, 1)), m, d,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
